// File: rtl/cdb_pkg.sv
// Shared CDB definitions: widths, broadcast message layout, and the null tag.
package cdb_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 4;

    // Tag 0 marks "no producer"; it is never driven onto the CDB as valid.
    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_msg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, with wrap-around.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] next_ptr
);

    // Scan ptr, ptr+1, ... mod N and stop at the first request.
    always_comb begin
        logic        found;
        int unsigned idx;
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                idx = (int'(ptr) + i) % N;
                if (!found && req[idx]) begin
                    grant[idx] = 1'b1;
                    next_ptr   = PTR_W'((idx + 1) % N);
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin accept of one result per cycle,
// broadcast from a register one cycle later.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int TAG_W   = cdb_pkg::TAG_W,
    parameter int DATA_W  = cdb_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic                      flush,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data
);

    localparam int PTR_W = $clog2(NUM_SRC);

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  rr_next;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;
    logic              any_grant;
    logic              tag_zero_drop;

    // Arbitration is suppressed outright during reset and flush, so no
    // source sees a transfer it would otherwise have to retract.
    rr_arbiter #(.N(NUM_SRC), .PTR_W(PTR_W)) u_rr (
        .req      (src_valid),
        .ptr      (rr_ptr),
        .en       (!rst && !flush),
        .grant    (src_ready),
        .next_ptr (rr_next)
    );

    assign any_grant = |src_ready;

    // One-hot grant lets the data mux collapse to an AND-OR.
    always_comb begin
        sel_tag  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_tag  |= {TAG_W{src_ready[i]}}  & src_tag[i*TAG_W +: TAG_W];
            sel_data |= {DATA_W{src_ready[i]}} & src_data[i*DATA_W +: DATA_W];
        end
    end

    // Broadcast register, round-robin pointer and tag-0 sticky status.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid     <= 1'b0;
            cdb_tag       <= '0;
            cdb_data      <= '0;
            rr_ptr        <= '0;
            tag_zero_drop <= 1'b0;
        end else if (any_grant) begin
            // A tag-0 result is consumed but never shown as valid.
            cdb_valid <= (sel_tag != TAG_W'(TAG_NONE));
            cdb_tag   <= sel_tag;
            cdb_data  <= sel_data;
            rr_ptr    <= rr_next;
            if (sel_tag == TAG_W'(TAG_NONE))
                tag_zero_drop <= 1'b1;
        end else begin
            // Idle or flushed: drop the broadcast, hold tag/data and pointer.
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (NUM_SRC=3, TAG_W=3, DATA_W=4).
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  src_valid;
    logic [8:0]  src_tag;
    logic [11:0] src_data;
    logic [2:0]  src_ready;
    logic        flush;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [3:0]  cdb_data;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_arbiter #(.NUM_SRC(3), .TAG_W(3), .DATA_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_tag   (src_tag),
        .src_data  (src_data),
        .src_ready (src_ready),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [2:0] t, input logic [3:0] d);
        src_tag[i*3 +: 3]  = t;
        src_data[i*4 +: 4] = d;
    endtask

    // Check the combinational ready, then cross an edge and check the bus.
    task automatic xfer(input string name, input logic [2:0] exp_rdy,
                        input logic exp_v, input logic [2:0] exp_t, input logic [3:0] exp_d);
        #1;
        chk({name, ".ready"}, 32'(src_ready), 32'(exp_rdy));
        tick();
        chk({name, ".cdb_valid"}, 32'(cdb_valid), 32'(exp_v));
        if (exp_v) begin
            chk({name, ".cdb_tag"},  32'(cdb_tag),  32'(exp_t));
            chk({name, ".cdb_data"}, 32'(cdb_data), 32'(exp_d));
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; src_valid = '0; src_tag = '0; src_data = '0;
        tick(); tick();
        chk("rst.cdb_valid", 32'(cdb_valid), 0);
        chk("rst.cdb_tag",   32'(cdb_tag),   0);
        chk("rst.cdb_data",  32'(cdb_data),  0);
        chk("rst.ptr",       32'(dut.rr_ptr), 0);
        rst = 1'b0;

        // Idle for 5 cycles
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("idle.ready", 32'(src_ready), 0);
            tick();
            chk("idle.cdb_valid", 32'(cdb_valid), 0);
            chk("idle.cdb_tag",   32'(cdb_tag),   0);
            chk("idle.cdb_data",  32'(cdb_data),  0);
        end

        // Single source, back-to-back
        set_src(0, 3'd2, 4'hA);
        src_valid = 3'b001;
        for (int c = 0; c < 4; c++) xfer("single", 3'b001, 1'b1, 3'd2, 4'hA);
        src_valid = 3'b000;
        xfer("single_end", 3'b000, 1'b0, 3'd0, 4'h0);
        chk("single.ptr", 32'(dut.rr_ptr), 1);

        // Restart pointer at 0 for the round-robin order check
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rr.ptr0", 32'(dut.rr_ptr), 0);
        set_src(0, 3'd1, 4'h1);
        set_src(1, 3'd2, 4'h2);
        set_src(2, 3'd3, 4'h3);
        src_valid = 3'b111;
        xfer("rr1", 3'b001, 1'b1, 3'd1, 4'h1);
        xfer("rr2", 3'b010, 1'b1, 3'd2, 4'h2);
        xfer("rr3", 3'b100, 1'b1, 3'd3, 4'h3);
        xfer("rr4", 3'b001, 1'b1, 3'd1, 4'h1);
        xfer("rr5", 3'b010, 1'b1, 3'd2, 4'h2);
        xfer("rr6", 3'b100, 1'b1, 3'd3, 4'h3);
        chk("rr.ptr", 32'(dut.rr_ptr), 0);

        // Wrap: move ptr to 2, then sources 0 and 2
        src_valid = 3'b010;
        xfer("wrap.pre", 3'b010, 1'b1, 3'd2, 4'h2);
        chk("wrap.ptr2", 32'(dut.rr_ptr), 2);
        src_valid = 3'b101;
        xfer("wrap.s2", 3'b100, 1'b1, 3'd3, 4'h3);
        src_valid = 3'b001;
        xfer("wrap.s0", 3'b001, 1'b1, 3'd1, 4'h1);
        chk("wrap.ptr1", 32'(dut.rr_ptr), 1);

        // Flush with sources 1 and 2 pending
        src_valid = 3'b110; flush = 1'b1;
        xfer("flush", 3'b000, 1'b0, 3'd0, 4'h0);
        chk("flush.ptr", 32'(dut.rr_ptr), 1);
        flush = 1'b0;
        src_valid = 3'b110;
        xfer("postflush", 3'b010, 1'b1, 3'd2, 4'h2);
        src_valid = 3'b100;
        xfer("postflush2", 3'b100, 1'b1, 3'd3, 4'h3);
        chk("postflush.ptr", 32'(dut.rr_ptr), 0);

        // Tag 0: consumed, not broadcast
        set_src(0, 3'd0, 4'h5);
        src_valid = 3'b001;
        xfer("tag0", 3'b001, 1'b0, 3'd0, 4'h0);
        chk("tag0.ptr",    32'(dut.rr_ptr), 1);
        chk("tag0.sticky", 32'(dut.tag_zero_drop), 1);
        set_src(0, 3'd1, 4'h1);

        // Reset in the cycle after a transfer
        src_valid = 3'b010;
        xfer("rstmid.xfer", 3'b010, 1'b1, 3'd2, 4'h2);
        src_valid = 3'b101; rst = 1'b1;
        #1;
        chk("rstmid.ready", 32'(src_ready), 0);
        chk("rstmid.pre_valid", 32'(cdb_valid), 1);
        tick();
        chk("rstmid.cdb_valid", 32'(cdb_valid), 0);
        chk("rstmid.ptr", 32'(dut.rr_ptr), 0);
        rst = 1'b0;
        xfer("rstmid.s0", 3'b001, 1'b1, 3'd1, 4'h1);
        src_valid = 3'b100;
        xfer("rstmid.s2", 3'b100, 1'b1, 3'd3, 4'h3);
        src_valid = 3'b000;
        xfer("end", 3'b000, 1'b0, 3'd0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
